fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, program-counter and instruction-address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_stall  input  1  hazard stall from decode; holds PC and IF/ID register.
REQ-007 i_branch_taken  input  1  redirect to i_branch_target this cycle.
REQ-008 i_branch_target  input  ADDR_WIDTH  branch destination.
REQ-009 i_jump  input  1  redirect to i_jump_target this cycle.
REQ-010 i_jump_target  input  ADDR_WIDTH  jump destination.
REQ-011 o_imem_addr  output  ADDR_WIDTH  byte address to instruction ROM.
REQ-012 i_imem_data  input  DATA_WIDTH  instruction word from ROM, combinational response to o_imem_addr.
REQ-013 o_instr  output  DATA_WIDTH  IF/ID instruction to decode.
REQ-014 o_pc  output  ADDR_WIDTH  IF/ID address of o_instr.
REQ-015 o_pc_plus4  output  ADDR_WIDTH  IF/ID o_pc + 4, for link and branch-offset computation.
REQ-016 o_valid  output  1  IF/ID contents are a real instruction (0 = bubble).

Function
REQ-017 o_imem_addr SHALL equal the PC register combinationally; ROM read latency is zero cycles, so the IF/ID register captures i_imem_data on the same edge the PC advances.
REQ-018 Next-PC priority per edge SHALL be: i_rst > i_branch_taken > i_jump > i_stall > sequential (PC + 4).
REQ-019 Sequential (no stall, no redirect): PC <= PC + 4; IF/ID <= {i_imem_data, PC, PC + 4}; o_valid <= 1.
REQ-020 Stall (no redirect): PC and all IF/ID outputs SHALL hold their values, o_valid included.
REQ-021 Branch taken: PC <= i_branch_target; IF/ID SHALL load a bubble (o_instr = 32'h0000_0000 NOP, o_valid = 0, o_pc and o_pc_plus4 = 0), squashing the wrong-path word fetched this cycle.
REQ-022 Jump (no branch): as REQ-021 with i_jump_target.
REQ-023 Branch and jump asserted together: branch target SHALL win.
REQ-024 Redirect coincident with stall: the redirect SHALL take effect (PC loads target, IF/ID becomes bubble); the stall is ignored that cycle.
REQ-025 Redirect targets SHALL be word-aligned on load: bits [1:0] forced to 00.
REQ-026 PC + 4 SHALL wrap modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 32'h0000_0000), with no flag raised.
REQ-027 The unit SHALL NOT range-check addresses; out-of-range handling belongs to the ROM.
REQ-028 At most one PC update per cycle; no internal state other than PC and the IF/ID register.

Reset
REQ-029 On an i_rst edge: PC <= RESET_PC with bits [1:0] cleared; o_instr <= 0; o_pc <= 0; o_pc_plus4 <= 0; o_valid <= 0.
REQ-030 Reset SHALL override stall and redirects asserted in the same cycle.
REQ-031 First cycle after reset deasserts: o_imem_addr = RESET_PC; the next edge SHALL capture mem[RESET_PC] with o_valid = 1 (given no stall or redirect).
REQ-032 Reset asserted mid-stream SHALL discard the in-flight IF/ID contents in one cycle.

Structure
REQ-033 Shared package/header SHALL hold: ADDR_WIDTH, DATA_WIDTH, RESET_PC, the NOP encoding 32'h0000_0000, and the PC increment constant 4.
REQ-034 One sub-module, pc_reg (PC register with next-PC mux, alignment, and reset), is natural; the IF/ID register stays in fetch_unit.
REQ-035 The ROM is instantiated outside fetch_unit, at the top level.

Verification
REQ-036 Reset, then 4 free-running cycles with ROM words 0x11,0x22,0x33,0x44 at 0x0-0xC -> o_pc 0,4,8,C; o_instr 0x11..0x44; o_valid 1 from the first post-reset edge.
REQ-037 i_stall high 2 cycles while o_pc = 8 -> o_pc, o_instr and o_imem_addr = 0xC all frozen; o_pc = 0xC one edge after the stall drops.
REQ-038 i_branch_taken with target 0x40 while o_imem_addr = 0x10 -> next o_valid = 0 and o_instr = 0; following edge o_pc = 0x40, o_valid = 1.
REQ-039 i_branch_taken (target 0x80) and i_jump (target 0x200) together with i_stall high -> o_imem_addr = 0x80 after the edge; target 0x83 also yields 0x80.
REQ-040 PC forced to 0xFFFF_FFFC -> next o_imem_addr = 0x0000_0000 and o_pc_plus4 = 0x0 for that instruction.
REQ-041 i_rst asserted mid-stream together with i_jump -> o_valid = 0 and o_imem_addr = RESET_PC after the edge.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int          FETCH_ADDR_WIDTH = 32;
    localparam int          FETCH_DATA_WIDTH = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_0000;
    // All-zero word doubles as the bubble encoding on the IF/ID register.
    localparam logic [31:0] FETCH_NOP        = 32'h0000_0000;
    localparam logic [31:0] FETCH_PC_INCR    = 32'd4;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: next-PC priority mux, word alignment of redirect targets, reset.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic                  i_jump,
    input  logic [ADDR_WIDTH-1:0] i_jump_target,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] PC_INCR    = ADDR_WIDTH'(FETCH_PC_INCR);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;

    // Increment wraps naturally at the top of the address space.
    assign pc_plus4 = pc_q + PC_INCR;

    // Next-PC select: branch beats jump, any redirect beats stall.
    always_comb begin
        pc_d = pc_plus4;
        if (i_branch_taken) begin
            pc_d = i_branch_target & ALIGN_MASK;
        end else if (i_jump) begin
            pc_d = i_jump_target & ALIGN_MASK;
        end else if (i_stall) begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous reset overriding everything.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC drives a zero-latency ROM, IF/ID register captures the word.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic [ADDR_WIDTH-1:0] i_branch_target,
    input  logic                  i_jump,
    input  logic [ADDR_WIDTH-1:0] i_jump_target,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_data,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic                  o_valid
);

    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(FETCH_NOP);

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] fetch_pc_plus4;
    logic                  redirect;

    logic [DATA_WIDTH-1:0] id_instr_q;
    logic [ADDR_WIDTH-1:0] id_pc_q;
    logic [ADDR_WIDTH-1:0] id_pc_plus4_q;
    logic                  id_valid_q;

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .o_pc            (fetch_pc),
        .o_pc_plus4      (fetch_pc_plus4)
    );

    assign o_imem_addr = fetch_pc;
    assign redirect    = i_branch_taken | i_jump;

    // IF/ID register: reset and redirect load a bubble, stall holds, otherwise capture the fetched word.
    always_ff @(posedge i_clk) begin
        if (i_rst || redirect) begin
            id_instr_q    <= NOP;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            id_valid_q    <= 1'b0;
        end else if (!i_stall) begin
            id_instr_q    <= i_imem_data;
            id_pc_q       <= fetch_pc;
            id_pc_plus4_q <= fetch_pc_plus4;
            id_valid_q    <= 1'b1;
        end
    end

    assign o_instr    = id_instr_q;
    assign o_pc       = id_pc_q;
    assign o_pc_plus4 = id_pc_plus4_q;
    assign o_valid    = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural ROM and reference model.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] addr;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic [31:0] i_branch_target = '0;
    logic        i_jump = 1'b0;
    logic [31:0] i_jump_target = '0;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_data;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic        o_valid;

    int n_vec  = 0;
    int n_miss = 0;

    exp_t sb_q[$];

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_pc4;
    logic        m_valid;
    logic        m_known = 1'b0;

    fetch_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_jump          (i_jump),
        .i_jump_target   (i_jump_target),
        .o_imem_addr     (o_imem_addr),
        .i_imem_data     (i_imem_data),
        .o_instr         (o_instr),
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_valid         (o_valid)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0: rom = 32'h11;
            32'h4: rom = 32'h22;
            32'h8: rom = 32'h33;
            32'hC: rom = 32'h44;
            default: rom = {16'hC0DE, a[17:2]};
        endcase
    endfunction

    always_comb i_imem_data = rom(o_imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the result, clock, then compare.
    task automatic step(input logic rst, input logic stall, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
        exp_t e;
        exp_t g;
        i_rst = rst; i_stall = stall; i_branch_taken = br; i_branch_target = bt;
        i_jump = j; i_jump_target = jt;
        #1;
        if (m_known) check("addr_pre", o_imem_addr, m_pc);
        if (rst) begin
            m_pc = 32'h0; m_instr = '0; m_id_pc = '0; m_id_pc4 = '0; m_valid = 1'b0;
            m_known = 1'b1;
        end else if (br || j) begin
            m_pc = br ? {bt[31:2], 2'b00} : {jt[31:2], 2'b00};
            m_instr = '0; m_id_pc = '0; m_id_pc4 = '0; m_valid = 1'b0;
        end else if (!stall) begin
            m_instr = rom(m_pc); m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e.instr = m_instr; e.pc = m_id_pc; e.pc4 = m_id_pc4; e.valid = m_valid; e.addr = m_pc;
        sb_q.push_back(e);
        @(posedge i_clk);
        #1;
        check("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            g = sb_q.pop_front();
            check("instr", o_instr, g.instr);
            check("pc", o_pc, g.pc);
            check("pc_plus4", o_pc_plus4, g.pc4);
            check("valid", {31'd0, o_valid}, {31'd0, g.valid});
            check("imem_addr", o_imem_addr, g.addr);
        end
    endtask

    task automatic seq();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        @(posedge i_clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_addr", o_imem_addr, 32'h0);

        seq();
        check("run_pc0", o_pc, 32'h0);
        check("run_instr0", o_instr, 32'h11);
        check("run_valid0", {31'd0, o_valid}, 32'd1);
        seq();
        check("run_instr1", o_instr, 32'h22);
        seq();
        check("run_pc2", o_pc, 32'h8);

        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            check("stall_pc", o_pc, 32'h8);
            check("stall_instr", o_instr, 32'h33);
            check("stall_addr", o_imem_addr, 32'hC);
        end
        seq();
        check("unstall_pc", o_pc, 32'hC);
        check("unstall_instr", o_instr, 32'h44);

        check("br_addr_pre", o_imem_addr, 32'h10);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("br_valid", {31'd0, o_valid}, 32'd0);
        check("br_instr", o_instr, 32'h0);
        seq();
        check("br_pc", o_pc, 32'h40);
        check("br_valid_after", {31'd0, o_valid}, 32'd1);

        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h200);
        check("brj_addr", o_imem_addr, 32'h80);
        step(1'b0, 1'b1, 1'b1, 32'h83, 1'b0, 32'h0);
        check("align_addr", o_imem_addr, 32'h80);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        seq();
        check("wrap_pc", o_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", o_pc_plus4, 32'h0);
        check("wrap_addr", o_imem_addr, 32'h0);

        seq();
        seq();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
        check("rstj_valid", {31'd0, o_valid}, 32'd0);
        check("rstj_addr", o_imem_addr, 32'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1237);
        check("jmp_align", o_imem_addr, 32'h1234);

        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, $urandom,
                 $urandom_range(0, 7) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
